// File: rtl/sinegen_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sinegen_sweep_ctrl_pkg
// Definitions shared by the sweep scheduler and its dwell timer:
//   - default widths for step values and the dwell counter
//   - sweep FSM state encoding (IDLE/RUN/DONE)
//   - sweep mode encodings and a helper that folds the reserved mode
// ---------------------------------------------------------------------------
package sinegen_sweep_ctrl_pkg;

  localparam int STEP_W_DEF  = 16;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  // The reserved code 3 behaves exactly like a single sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_SINGLE : mode;
  endfunction

endpackage

// File: rtl/sinegen_sweep_ctrl_dwell_timer.sv
// ---------------------------------------------------------------------------
// sinegen_dwell_timer
// Loadable down-counter that paces the sweep. o_tick is high whenever the
// count is zero; the owner reloads it on the same edge it consumes the tick,
// so a load value of D gives one tick every D+1 enabled cycles.
//   i_clk      system clock
//   i_rst      synchronous active-high reset (count -> 0)
//   i_load     load i_load_val (has priority over i_en)
//   i_en       decrement by one when non-zero
//   i_load_val value to load
//   o_tick     count is zero
// ---------------------------------------------------------------------------
module sinegen_dwell_timer
  import sinegen_sweep_ctrl_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_load_val,
  output logic               o_tick
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/sinegen_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sinegen_sweep_ctrl
// Frequency-sweep scheduler for the LUT sine generator. A start command
// latches a sweep configuration; the step (phase increment) then moves from
// the start value toward the stop value, each value held for dwell+1 cycles.
// Single, repeating and ping-pong sweeps are supported.
//
// Control pulses: i_start and i_abort are single-cycle requests sampled at
// the clock edge. i_start is honoured only in IDLE and only when i_abort is
// low; i_abort is honoured in every state. There is no back-pressure.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_abort      control pulses
//   i_step_start/stop/inc sweep range and increment (inc 0 is taken as 1)
//   i_dwell               each step held for i_dwell+1 cycles
//   i_mode                0 single, 1 repeat, 2 ping-pong, 3 = single
//   i_scale               amplitude shift code, latched at start
//   o_step, o_scale       registered controls to the sine generator
//   o_busy                sweep running
//   o_done                one-cycle pulse when a single sweep completes
//   o_dir                 current direction, 0 up, 1 down
//   o_dbg_state           current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module sinegen_sweep_ctrl
  import sinegen_sweep_ctrl_pkg::*;
#(
  parameter int STEP_W  = STEP_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [STEP_W-1:0]  i_step_start,
  input  logic [STEP_W-1:0]  i_step_stop,
  input  logic [STEP_W-1:0]  i_step_inc,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_scale,
  output logic [STEP_W-1:0]  o_step,
  output logic [1:0]         o_scale,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_dir,
  output logic [1:0]         o_dbg_state
);

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [STEP_W-1:0]  start_q, start_d;
  logic [STEP_W-1:0]  stop_q, stop_d;
  logic [STEP_W-1:0]  inc_q, inc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         scale_q, scale_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load, tmr_en, tmr_tick;
  logic [DWELL_W-1:0] tmr_val;

  logic [STEP_W-1:0]  step_up_v, step_dn_v;
  logic               leg_end;

  // Upward step: the sum is one bit wider so a wrap past the top of the
  // range is seen as "beyond stop" and clamped instead of wrapping.
  function automatic logic [STEP_W-1:0] step_up(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] stop,
    input logic [STEP_W-1:0] inc
  );
    logic [STEP_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > {1'b0, stop}) ? stop : sum[STEP_W-1:0];
  endfunction

  // Downward step: clamps at start, comparing against start+inc so the
  // subtraction itself can never underflow.
  function automatic logic [STEP_W-1:0] step_down(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] start,
    input logic [STEP_W-1:0] inc
  );
    logic [STEP_W:0] floor_v;
    floor_v = {1'b0, start} + {1'b0, inc};
    return ({1'b0, cur} < floor_v) ? start : (cur - inc);
  endfunction

  sinegen_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_en       (tmr_en),
    .i_load_val (tmr_val),
    .o_tick     (tmr_tick)
  );

  assign step_up_v = step_up(step_q, stop_q, inc_q);
  assign step_dn_v = step_down(step_q, start_q, inc_q);
  assign leg_end   = dir_q ? (step_q <= start_q) : (step_q >= stop_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_SINGLE;
      scale_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      scale_q <= scale_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    scale_d  = scale_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = dwell_q;

    case (state_q)
      IDLE: begin
        step_d = '0;
        busy_d = 1'b0;
        dir_d  = 1'b0;
        if (i_start && !i_abort) begin
          start_d  = i_step_start;
          stop_d   = i_step_stop;
          inc_d    = (i_step_inc == '0) ? STEP_W'(1) : i_step_inc;
          dwell_d  = i_dwell;
          mode_d   = norm_mode(i_mode);
          scale_d  = i_scale;
          step_d   = i_step_start;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = i_dwell;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
          step_d  = '0;
          busy_d  = 1'b0;
          dir_d   = 1'b0;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tick) begin
            tmr_load = 1'b1;
            if (!leg_end) begin
              step_d = dir_q ? step_dn_v : step_up_v;
            end else begin
              case (mode_q)
                MODE_REPEAT: begin
                  step_d = start_q;
                  dir_d  = 1'b0;
                end
                MODE_PINGPONG: begin
                  dir_d = ~dir_q;
                  // A degenerate range (start >= stop) just holds the step
                  // while the direction keeps flipping each dwell.
                  if (start_q < stop_q) begin
                    step_d = dir_q ? step_up_v : step_dn_v;
                  end
                end
                default: begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  step_d  = '0;
                  busy_d  = 1'b0;
                  dir_d   = 1'b0;
                end
              endcase
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        step_d  = '0;
        busy_d  = 1'b0;
        dir_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
        step_d  = '0;
        busy_d  = 1'b0;
        dir_d   = 1'b0;
      end
    endcase
  end

  assign o_step      = step_q;
  assign o_scale     = scale_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_dir       = dir_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sinegen_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sinegen_sweep_ctrl
// Sweep scheduler bench. Each accepted start expands the sweep into a
// per-cycle list of expected outputs built from whole legs (up leg, down
// leg) repeated according to the mode; a negedge process pops one entry per
// cycle and compares, an empty list meaning "idle".
// ---------------------------------------------------------------------------
module tb_sinegen_sweep_ctrl;

  localparam int STEP_W  = 16;
  localparam int DWELL_W = 16;
  localparam int MAXC    = 400;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic [1:0]        scale;
    logic              busy;
    logic              done;
    logic              dir;
  } exp_t;

  // clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic               i_rst;
  logic               i_start;
  logic               i_abort;
  logic [STEP_W-1:0]  i_step_start;
  logic [STEP_W-1:0]  i_step_stop;
  logic [STEP_W-1:0]  i_step_inc;
  logic [DWELL_W-1:0] i_dwell;
  logic [1:0]         i_mode;
  logic [1:0]         i_scale;
  logic [STEP_W-1:0]  o_step;
  logic [1:0]         o_scale;
  logic               o_busy;
  logic               o_done;
  logic               o_dir;
  logic [1:0]         o_dbg_state;

  sinegen_sweep_ctrl #(
    .STEP_W  (STEP_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_step_start (i_step_start),
    .i_step_stop  (i_step_stop),
    .i_step_inc   (i_step_inc),
    .i_dwell      (i_dwell),
    .i_mode       (i_mode),
    .i_scale      (i_scale),
    .o_step       (o_step),
    .o_scale      (o_scale),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_dir        (o_dir),
    .o_dbg_state  (o_dbg_state)
  );

  // scoreboard state
  exp_t exp_q[$];
  exp_t gen_q[$];
  int   up_leg[$];
  int   dn_leg[$];
  exp_t cur_e;
  bit   chk_en    = 1'b0;
  bit   last_done = 1'b0;
  int   n_vec     = 0;
  int   n_err     = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---- reference model: expand a sweep into per-cycle expectations ----
  task automatic visit(input int step, input bit dir, input int dw, input logic [1:0] sc);
    exp_t e;
    for (int c = 0; c <= dw; c++) begin
      if (gen_q.size() < MAXC) begin
        e.step  = 16'(step);
        e.scale = sc;
        e.busy  = 1'b1;
        e.done  = 1'b0;
        e.dir   = dir;
        gen_q.push_back(e);
      end
    end
  endtask

  task automatic build(input int s, input int p, input int inc, input int dw,
                       input int md_in, input logic [1:0] sc);
    int   inc_e, md, v;
    bit   d;
    exp_t e;
    gen_q.delete();
    up_leg.delete();
    dn_leg.delete();
    inc_e = (inc == 0) ? 1 : inc;
    md    = (md_in == 3) ? 0 : md_in;
    // up leg: start, then +inc clamped at stop
    v = s;
    up_leg.push_back(v);
    while (v < p) begin
      v = (v + inc_e > p) ? p : v + inc_e;
      up_leg.push_back(v);
    end
    // down leg: stop, then -inc clamped at start
    if (s < p) begin
      v = p;
      dn_leg.push_back(v);
      while (v > s) begin
        v = (v < s + inc_e) ? s : v - inc_e;
        dn_leg.push_back(v);
      end
    end
    if (md == 0) begin
      foreach (up_leg[i]) visit(up_leg[i], 1'b0, dw, sc);
      if (up_leg.size() * (dw + 1) <= MAXC) begin
        e = '0;
        e.done = 1'b1;
        gen_q.push_back(e);
      end
    end else if (md == 1) begin
      while (gen_q.size() < MAXC)
        foreach (up_leg[i]) visit(up_leg[i], 1'b0, dw, sc);
    end else if (s >= p) begin
      d = 1'b0;
      while (gen_q.size() < MAXC) begin
        visit(s, d, dw, sc);
        d = !d;
      end
    end else begin
      foreach (up_leg[i]) visit(up_leg[i], 1'b0, dw, sc);
      while (gen_q.size() < MAXC) begin
        for (int i = 1; i < dn_leg.size(); i++) visit(dn_leg[i], 1'b1, dw, sc);
        for (int i = 1; i < up_leg.size(); i++) visit(up_leg[i], 1'b0, dw, sc);
      end
    end
  endtask

  // ---- per-cycle compare ----
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur_e = exp_q.pop_front();
      else cur_e = '0;
      last_done = cur_e.done;
      chk("step", 32'(o_step), 32'(cur_e.step));
      chk("busy", 32'(o_busy), 32'(cur_e.busy));
      chk("done", 32'(o_done), 32'(cur_e.done));
      chk("dir", 32'(o_dir), 32'(cur_e.dir));
      if (cur_e.busy) chk("scale", 32'(o_scale), 32'(cur_e.scale));
      chk("state", 32'(o_dbg_state), cur_e.busy ? 32'd1 : (cur_e.done ? 32'd2 : 32'd0));
    end
  end

  // ---- driver tasks ----
  task automatic next();
    @(negedge i_clk);
    #1;
  endtask

  task automatic start_sweep(input int s, input int p, input int inc, input int dw,
                             input int md, input int sc, input bit ab);
    i_step_start = 16'(s);
    i_step_stop  = 16'(p);
    i_step_inc   = 16'(inc);
    i_dwell      = 16'(dw);
    i_mode       = 2'(md);
    i_scale      = 2'(sc);
    if (!ab && exp_q.size() == 0 && !last_done) begin
      build(s, p, inc, dw, md, 2'(sc));
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
    end
    i_start = 1'b1;
    i_abort = ab;
    next();
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic abort_now();
    i_abort = 1'b1;
    exp_q.delete();
    next();
    i_abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      next();
      b--;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL wait_idle: %0d expected cycles left after budget %0d", exp_q.size(), budget);
      abort_now();
    end
    next();
  endtask

  task automatic jitter();
    i_step_start = 16'($urandom_range(0, 16'hFFFF));
    i_step_stop  = 16'($urandom_range(0, 16'hFFFF));
    i_step_inc   = 16'($urandom_range(0, 16'hFFFF));
    i_dwell      = 16'($urandom_range(0, 3));
    i_mode       = 2'($urandom_range(0, 3));
    i_scale      = 2'($urandom_range(0, 3));
  endtask

  task automatic rand_start();
    int s, p, inc;
    s   = $urandom_range(0, 16'hFFFF);
    p   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16'hFFFF)
                                      : (s + $urandom_range(0, 16'h0800)) % 65536;
    inc = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 16'h0200);
    start_sweep(s, p, inc, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b0);
  endtask

  // ---- main sequence ----
  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_step_start = '0;
    i_step_stop = '0;
    i_step_inc = '0;
    i_dwell = '0;
    i_mode = '0;
    i_scale = '0;
    next();
    next();
    chk_en = 1'b1;
    chk("rst_scale", 32'(o_scale), 32'd0);
    i_rst = 1'b0;
    next();

    // model pins: single sweep
    build(16'h0100, 16'h0400, 16'h0100, 2, 0, 2'd0);
    chk("pin_t1_len", gen_q.size(), 13);
    chk("pin_t1_c1", 32'(gen_q[0].step), 32'h0100);
    chk("pin_t1_c3", 32'(gen_q[2].step), 32'h0100);
    chk("pin_t1_c4", 32'(gen_q[3].step), 32'h0200);
    chk("pin_t1_c12", 32'(gen_q[11].step), 32'h0400);
    chk("pin_t1_done", 32'(gen_q[12].done), 32'd1);
    start_sweep(16'h0100, 16'h0400, 16'h0100, 2, 0, 1, 1'b0);
    wait_idle(50);

    // clamp / overflow
    build(16'hFF00, 16'hFFFF, 16'h0200, 0, 0, 2'd0);
    chk("pin_t2_len", gen_q.size(), 3);
    chk("pin_t2_s0", 32'(gen_q[0].step), 32'hFF00);
    chk("pin_t2_s1", 32'(gen_q[1].step), 32'hFFFF);
    start_sweep(16'hFF00, 16'hFFFF, 16'h0200, 0, 0, 3, 1'b0);
    wait_idle(20);
    build(16'h0100, 16'h0250, 16'h0100, 0, 0, 2'd0);
    chk("pin_t2b_s2", 32'(gen_q[2].step), 32'h0250);
    chk("pin_t2b_done", 32'(gen_q[3].done), 32'd1);
    start_sweep(16'h0100, 16'h0250, 16'h0100, 0, 0, 0, 1'b0);
    wait_idle(20);

    // ping-pong
    build(1, 3, 1, 0, 2, 2'd0);
    chk("pin_pp_seq", {gen_q[0].step[3:0], gen_q[1].step[3:0], gen_q[2].step[3:0],
                       gen_q[3].step[3:0], gen_q[4].step[3:0], gen_q[5].step[3:0],
                       gen_q[6].step[3:0]}, 28'h1232123);
    chk("pin_pp_dir", {gen_q[0].dir, gen_q[1].dir, gen_q[2].dir, gen_q[3].dir,
                       gen_q[4].dir, gen_q[5].dir, gen_q[6].dir}, 7'b0001100);
    start_sweep(1, 3, 1, 0, 2, 2, 1'b0);
    repeat (30) next();
    abort_now();
    next();

    // repeat
    build(5, 7, 1, 1, 1, 2'd0);
    chk("pin_rep_seq", {gen_q[0].step[3:0], gen_q[1].step[3:0], gen_q[2].step[3:0],
                        gen_q[3].step[3:0], gen_q[4].step[3:0], gen_q[5].step[3:0],
                        gen_q[6].step[3:0], gen_q[7].step[3:0]}, 32'h55667755);
    start_sweep(5, 7, 1, 1, 1, 1, 1'b0);
    repeat (30) next();
    abort_now();
    next();

    // abort at cycle 4 of the single sweep
    start_sweep(16'h0100, 16'h0400, 16'h0100, 2, 0, 1, 1'b0);
    next();
    next();
    next();
    abort_now();
    repeat (5) next();

    // start + abort together in IDLE
    start_sweep(16'h0100, 16'h0400, 16'h0100, 2, 0, 1, 1'b1);
    repeat (3) next();

    // start during RUN, and start during DONE
    start_sweep(16'h0100, 16'h0400, 16'h0100, 2, 0, 1, 1'b0);
    next();
    start_sweep(16'h0010, 16'h0020, 16'h0001, 0, 1, 3, 1'b0);
    wait_idle(50);
    start_sweep(16'hFF00, 16'hFFFF, 16'h0200, 0, 0, 3, 1'b0);
    next();
    start_sweep(16'h0010, 16'h0020, 16'h0001, 0, 1, 3, 1'b0);
    repeat (4) next();

    // reset mid-run
    start_sweep(16'h0100, 16'h0400, 16'h0100, 2, 0, 3, 1'b0);
    repeat (3) next();
    i_rst = 1'b1;
    exp_q.delete();
    next();
    chk("rst_mid_scale", 32'(o_scale), 32'd0);
    i_rst = 1'b0;
    next();

    // inc = 0, scale latched while inputs change
    build(10, 12, 0, 0, 0, 2'd0);
    chk("pin_inc0_seq", {gen_q[0].step[7:0], gen_q[1].step[7:0], gen_q[2].step[7:0]}, 24'h0A0B0C);
    chk("pin_inc0_done", 32'(gen_q[3].done), 32'd1);
    start_sweep(10, 12, 0, 0, 0, 2, 1'b0);
    i_scale = 2'd1;
    i_step_stop = 16'h00FF;
    wait_idle(20);

    // randomized sweeps with collisions and config jitter
    for (int r = 0; r < 40; r++) begin
      int n;
      rand_start();
      n = $urandom_range(5, 120);
      for (int c = 0; c < n; c++) begin
        int x;
        x = $urandom_range(0, 29);
        if (x == 0) abort_now();
        else if (x == 1) rand_start();
        else begin
          jitter();
          next();
        end
      end
      if (exp_q.size() > 0) abort_now();
      next();
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
